// File: rtl/mdu_e_stage_if.sv
// mdu_e_stage_if: E-stage MDU bus (master = pipeline drives A/B/MDU_op/start/HILO_sel; slave = MDU returns busy/MDU_out)
interface mdu_e_stage_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0] MDU_op;
  logic start;
  logic HILO_sel;
  logic busy;
  logic [31:0] MDU_out;
  modport master(output A, output B, output MDU_op, output start, output HILO_sel, input busy, input MDU_out);
  modport slave(input A, input B, input MDU_op, input start, input HILO_sel, output busy, output MDU_out);
endinterface

// File: rtl/mdu_e_stage.sv
// mdu_e_stage: multi-cycle mult/div unit with HI/LO regs; ports clk, reset (sync, active-high), bus (slave: A, B, MDU_op, start, HILO_sel in; busy, MDU_out out)
module mdu_e_stage #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_e_stage_if.slave bus
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [63:0] res_q, res_d, res_c, pu;
  logic signed [63:0] ps;
  logic [31:0] ma, mb, qm, rm, uq, ur;
  logic launch, done, is_div, keep;
  always_comb begin
    launch = state_q == IDLE && bus.start && bus.MDU_op >= 3'd1 && bus.MDU_op <= 3'd4;
    done = state_q == RUN && cnt_q == CW'(1);
    is_div = bus.MDU_op == 3'd3 || bus.MDU_op == 3'd4;
    keep = op_q >= 3'd3 && b_q == '0;
    ps = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    pu = {32'b0, bus.A} * {32'b0, bus.B};
    ma = bus.A[31] ? -bus.A : bus.A;
    mb = bus.B[31] ? -bus.B : bus.B;
    qm = mb == '0 ? '0 : ma / mb;
    rm = mb == '0 ? '0 : ma % mb;
    uq = bus.B == '0 ? '0 : bus.A / bus.B;
    ur = bus.B == '0 ? '0 : bus.A % bus.B;
    res_c = bus.MDU_op == 3'd1 ? ps
          : bus.MDU_op == 3'd2 ? pu
          : bus.MDU_op == 3'd3 ? {(bus.A[31] ? -rm : rm), (bus.A[31] ^ bus.B[31] ? -qm : qm)}
          : {ur, uq};
  end
  always_comb begin
    state_d = launch ? RUN : done ? IDLE : state_q;
  end
  always_comb begin
    cnt_d = launch ? (is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES)) : state_q == RUN ? cnt_q - CW'(1) : cnt_q;
    b_d = launch ? bus.B : b_q;
    op_d = launch ? bus.MDU_op : op_q;
    res_d = launch ? res_c : res_q;
    hi_d = done && !keep ? res_q[63:32] : state_q == IDLE && bus.MDU_op == 3'd5 ? bus.A : hi_q;
    lo_d = done && !keep ? res_q[31:0] : state_q == IDLE && bus.MDU_op == 3'd6 ? bus.A : lo_q;
  end
  always_comb begin
    bus.busy = state_q == RUN;
    bus.MDU_out = bus.HILO_sel ? hi_q : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_mdu_e_stage.sv
// tb_mdu_e_stage: directed plus random checks of mdu_e_stage against an arithmetic reference model
module tb_mdu_e_stage;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mdu_e_stage_if bus();
  mdu_e_stage #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    bus.HILO_sel = 1'b1;
    #1;
    chk({tag, "_hi"}, bus.MDU_out, hi_m);
    bus.HILO_sel = 1'b0;
    #1;
    chk({tag, "_lo"}, bus.MDU_out, lo_m);
  endtask
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint unsigned u;
    case (op)
      3'd1: begin
        p = longint'(int'(a)) * longint'(int'(b));
        {hi_m, lo_m} = p;
      end
      3'd2: begin
        u = longint'({32'b0, a}) * longint'({32'b0, b});
        {hi_m, lo_m} = u;
      end
      3'd3: if (b != 0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo_m = 32'h80000000;
          hi_m = 32'h0;
        end else begin
          lo_m = 32'(int'(a) / int'(b));
          hi_m = 32'(int'(a) % int'(b));
        end
      end
      3'd4: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endfunction
  task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] mid_op, input logic mid_start, input logic [31:0] mid_a);
    int n;
    int exp_n;
    n = 0;
    exp_n = (op >= 3'd3) ? DIV_N : MUL_N;
    bus.start = 1'b1;
    bus.MDU_op = op;
    bus.A = a;
    bus.B = b;
    step();
    bus.MDU_op = mid_op;
    bus.start = mid_start;
    bus.A = mid_a;
    bus.B = mid_a;
    while (bus.busy === 1'b1 && n < 100) begin
      if (n == exp_n - 1) chk_regs({tag, "_inflight"});
      n++;
      step();
    end
    bus.start = 1'b0;
    bus.MDU_op = 3'd0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    model(op, a, b);
    chk_regs(tag);
  endtask
  task automatic mt(input string tag, input logic [2:0] op, input logic s, input logic [31:0] a);
    bus.MDU_op = op;
    bus.start = s;
    bus.A = a;
    bus.B = a;
    chk_regs({tag, "_pre"});
    step();
    bus.MDU_op = 3'd0;
    bus.start = 1'b0;
    if (op == 3'd5 || op == 3'd6) model(op, a, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk_regs(tag);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int n;
    bus.A = '0;
    bus.B = '0;
    bus.MDU_op = '0;
    bus.start = 1'b0;
    bus.HILO_sel = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk_regs("reset");
    run_mdu("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 3'd0, 1'b0, 32'd0);
    run_mdu("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 32'd0);
    run_mdu("div", 3'd3, 32'hFFFFFFF9, 32'd2, 3'd0, 1'b0, 32'd0);
    run_mdu("divu_zero", 3'd4, 32'd7, 32'd0, 3'd0, 1'b0, 32'd0);
    run_mdu("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 3'd0, 1'b0, 32'd0);
    run_mdu("div_zero", 3'd3, 32'd5, 32'd0, 3'd0, 1'b0, 32'd0);
    mt("mtlo", 3'd6, 1'b0, 32'h1234);
    mt("mthi", 3'd5, 1'b0, 32'hABCD0000);
    run_mdu("mthi_busy", 3'd1, 32'd2, 32'd3, 3'd5, 1'b0, 32'hDEADBEEF);
    run_mdu("restart_ignored", 3'd3, 32'd100, 32'd7, 3'd4, 1'b1, 32'h55);
    mt("start_mthi", 3'd5, 1'b1, 32'h77);
    mt("op7", 3'd7, 1'b1, 32'h99);
    mt("mult_nostart", 3'd1, 1'b0, 32'h5);
    mt("nop_start", 3'd0, 1'b1, 32'h6);
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (op <= 3'd4) run_mdu("rand", op, a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      else mt("rand_mt", op, 1'($urandom_range(0, 1)), a);
    end
    mt("pre_rst", 3'd6, 1'b0, 32'hCAFE);
    bus.start = 1'b1;
    bus.MDU_op = 3'd1;
    bus.A = 32'd5;
    bus.B = 32'd7;
    step();
    bus.start = 1'b0;
    bus.MDU_op = 3'd0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk_regs("rst_mid");
    repeat (12) step();
    chk("rst_mid_late_busy", 32'(bus.busy), 32'd0);
    chk_regs("rst_mid_late");
    bus.start = 1'b1;
    bus.MDU_op = 3'd1;
    bus.A = 32'd2;
    bus.B = 32'd3;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5) begin
        model(3'd1, 32'd2, 32'd3);
        chk("held_gap_busy", 32'(bus.busy), 32'd0);
        chk_regs("held_done");
      end else begin
        chk("held_busy", 32'(bus.busy), 32'd1);
      end
    end
    bus.start = 1'b0;
    bus.MDU_op = 3'd0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("held_second_cycles", 32'(n), 32'(MUL_N - 1));
    chk_regs("held_second");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
